// File: rtl/fwd_hazard_ctrl.sv
// Operand bypass select generation for the EX stage plus load-use hazard
// detection with a latency-sized stall sequencer and a saturating stall counter.
module fwd_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 16,
    parameter int EN_LATE_FWD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_uses_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    input  logic              flush,
    input  logic              stall_clr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [REG_AW-1:0]   late_rd_q, late_rd_d;
    logic                late_we_q, late_we_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                hz;
    logic                stall_c;

    // Priority: youngest producer wins; register 0 is never bypassed.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] em_rd,
        input logic              em_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic              mw_we,
        input logic [REG_AW-1:0] lt_rd,
        input logic              lt_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (em_we && (em_rd != '0) && (em_rd == src)) begin
            sel = 2'b10;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
            sel = 2'b01;
        end else if ((EN_LATE_FWD != 0) && lt_we && (lt_rd != '0) && (lt_rd == src)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
                        late_rd_q, late_we_q);
        fwd_b = 2'b00;
        if (ex_uses_rt) begin
            fwd_b = fwd_sel(ex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
                            late_rd_q, late_we_q);
        end
    end

    always_comb begin
        hz = idex_memread && idex_regwrite && (idex_rd != '0) &&
             ((id_uses_rs && (idex_rd == id_rs)) || (id_uses_rt && (idex_rd == id_rt)));
    end

    // The first stall cycle is spent in IDLE; STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = hz && !flush;
                if (stall_c && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = 4'(LOAD_LAT - 1);
                end
            end
            STALL: begin
                stall_c = !flush;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        late_rd_d   = memwb_rd;
        late_we_d   = memwb_regwrite;
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Held low while reset is asserted so the front end is released immediately.
    assign stall       = stall_c && rst_n;
    assign idex_bubble = stall;
    assign stall_cnt   = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            late_rd_q   <= '0;
            late_we_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            late_rd_q   <= late_rd_d;
            late_we_q   <= late_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Three controller variants share one stimulus stream and are checked every
// cycle against a stall-window / producer-list model, plus directed scenarios.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, idex_rd, exmem_rd, memwb_rd;
    logic       id_uses_rs, id_uses_rt, ex_uses_rt, idex_regwrite, idex_memread;
    logic       exmem_regwrite, memwb_regwrite, flush, stall_clr;

    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic        st [3];
    logic        bb [3];
    logic [15:0] sc0, sc2;
    logic [3:0]  sc1;

    int n_checks = 0;
    int n_errors = 0;

    // Variant 0: LAT 1, 16-bit count, late fwd. 1: LAT 3, 4-bit count. 2: LAT 2, no late fwd.
    int lat  [3] = '{1, 3, 2};
    int cmax [3] = '{65535, 15, 65535};
    int enl  [3] = '{1, 1, 0};

    int         rem  [3];
    int         mcnt [3];
    logic [4:0] late_rd_m;
    logic       late_we_m;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16), .EN_LATE_FWD(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_uses_rt(ex_uses_rt), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
        .idex_memread(idex_memread), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .flush(flush),
        .stall_clr(stall_clr), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall(st[0]),
        .idex_bubble(bb[0]), .stall_cnt(sc0));

    fwd_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4), .EN_LATE_FWD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_uses_rt(ex_uses_rt), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
        .idex_memread(idex_memread), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .flush(flush),
        .stall_clr(stall_clr), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall(st[1]),
        .idex_bubble(bb[1]), .stall_cnt(sc1));

    fwd_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16), .EN_LATE_FWD(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_uses_rt(ex_uses_rt), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
        .idex_memread(idex_memread), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .flush(flush),
        .stall_clr(stall_clr), .fwd_a(fa[2]), .fwd_b(fb[2]), .stall(st[2]),
        .idex_bubble(bb[2]), .stall_cnt(sc2));

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s[dut%0d] t=%0t: got %0d, expected %0d", nm, k, $time, act, exp);
        end
    endtask

    function automatic int dut_cnt(input int k);
        if (k == 0) return int'(sc0);
        if (k == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    // Reference: walk the producers youngest-first and take the first usable match.
    function automatic int m_fwd(input logic [4:0] src, input logic used, input int k);
        if (!used || src == 5'd0) return 0;
        if (exmem_regwrite && exmem_rd == src) return 2;
        if (memwb_regwrite && memwb_rd == src) return 1;
        if (enl[k] != 0 && rst_n && late_we_m && late_rd_m == src) return 3;
        return 0;
    endfunction

    function automatic logic m_hz();
        return idex_memread && idex_regwrite && idex_rd != 5'd0 &&
               ((id_uses_rs && idex_rd == id_rs) || (id_uses_rt && idex_rd == id_rt));
    endfunction

    // rem[k] = stall cycles still owed from a hazard already accepted.
    function automatic logic m_stall(input int k);
        if (!rst_n) return 1'b0;
        if (rem[k] == 0) return m_hz() && !flush;
        return !flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                rem[k]  <= 0;
                mcnt[k] <= 0;
            end
            late_rd_m <= 5'd0;
            late_we_m <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) rem[k] <= m_stall(k) ? lat[k] - 1 : 0;
                else             rem[k] <= flush ? 0 : rem[k] - 1;
                if (stall_clr)                       mcnt[k] <= 0;
                else if (m_stall(k) && mcnt[k] < cmax[k]) mcnt[k] <= mcnt[k] + 1;
            end
            late_rd_m <= memwb_rd;
            late_we_m <= memwb_regwrite;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("fwd_a", k, int'(fa[k]), m_fwd(ex_rs, 1'b1, k));
            chk("fwd_b", k, int'(fb[k]), m_fwd(ex_rt, ex_uses_rt, k));
            chk("stall", k, int'(st[k]), int'(m_stall(k)));
            chk("idex_bubble", k, int'(bb[k]), int'(m_stall(k)));
            chk("stall_cnt", k, dut_cnt(k), mcnt[k]);
        end
    end

    task automatic idle_in();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_uses_rt = 0;
        idex_rd = 0; idex_regwrite = 0; idex_memread = 0;
        exmem_rd = 0; exmem_regwrite = 0; memwb_rd = 0; memwb_regwrite = 0;
        flush = 0; stall_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_hazard(input logic [4:0] r);
        idex_memread = 1; idex_regwrite = 1; idex_rd = r; id_rs = r; id_uses_rs = 1;
    endtask

    initial begin
        idle_in();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-cycle and three-cycle load-use stalls.
        step(); idle_in(); stall_clr = 1; @(negedge clk);
        step(); stall_clr = 0; load_hazard(5'd5); @(negedge clk);
        chk("lat1_stall", 0, int'(st[0]), 1);
        chk("lat1_bubble", 0, int'(bb[0]), 1);
        step(); idle_in(); exmem_rd = 5; exmem_regwrite = 1; ex_rs = 5; @(negedge clk);
        chk("lat1_release", 0, int'(st[0]), 0);
        chk("load_fwd_a", 0, int'(fa[0]), 2);
        chk("lat1_count", 0, int'(sc0), 1);
        chk("lat3_cycle2", 1, int'(st[1]), 1);
        step(); idle_in(); @(negedge clk);
        chk("lat3_cycle3", 1, int'(st[1]), 1);
        step(); @(negedge clk);
        chk("lat3_release", 1, int'(st[1]), 0);
        chk("lat3_count", 1, int'(sc1), 3);

        // Flush in the second stall cycle.
        step(); load_hazard(5'd6); @(negedge clk);
        chk("flush_pre", 1, int'(st[1]), 1);
        step(); idle_in(); flush = 1; @(negedge clk);
        chk("flush_cycle", 1, int'(st[1]), 0);
        step(); flush = 0; @(negedge clk);
        chk("flush_after", 1, int'(st[1]), 0);

        // Producer priority, including the late stage.
        step(); exmem_rd = 7; memwb_rd = 7; exmem_regwrite = 1; memwb_regwrite = 1; ex_rs = 7;
        @(negedge clk);
        chk("prio_exmem", 0, int'(fa[0]), 2);
        step(); exmem_regwrite = 0; @(negedge clk);
        chk("prio_memwb", 0, int'(fa[0]), 1);
        step(); memwb_regwrite = 0; @(negedge clk);
        chk("prio_late", 0, int'(fa[0]), 3);
        chk("prio_late_off", 2, int'(fa[2]), 0);

        // Zero register never forwards or stalls.
        step(); idle_in(); exmem_regwrite = 1; ex_uses_rt = 1; load_hazard(5'd0); @(negedge clk);
        chk("zero_fwd_a", 0, int'(fa[0]), 0);
        chk("zero_fwd_b", 0, int'(fb[0]), 0);
        chk("zero_stall", 1, int'(st[1]), 0);

        // ex_uses_rt gating and simultaneous selects.
        step(); idle_in(); exmem_rd = 9; exmem_regwrite = 1; ex_rt = 9; @(negedge clk);
        chk("rt_unused", 0, int'(fb[0]), 0);
        step(); ex_uses_rt = 1; @(negedge clk);
        chk("rt_used", 0, int'(fb[0]), 2);
        step(); ex_rs = 9; @(negedge clk);
        chk("both_a", 0, int'(fa[0]), 2);
        chk("both_b", 0, int'(fb[0]), 2);

        // Continuous hazards saturate the 4-bit counter; then async reset mid-stall.
        step(); idle_in(); load_hazard(5'd3);
        repeat (20) step();
        @(negedge clk);
        chk("saturate", 1, int'(sc1), 15);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stall", 1, int'(st[1]), 0);
        chk("rst_cnt", 1, int'(sc1), 0);
        #1 rst_n = 1'b1;

        // Randomised traffic over a small register window to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            step();
            id_rs = 5'($urandom_range(0, 7));  id_rt = 5'($urandom_range(0, 7));
            ex_rs = 5'($urandom_range(0, 7));  ex_rt = 5'($urandom_range(0, 7));
            idex_rd = 5'($urandom_range(0, 7));
            exmem_rd = 5'($urandom_range(0, 7));
            memwb_rd = 5'($urandom_range(0, 7));
            id_uses_rs = 1'($urandom);  id_uses_rt = 1'($urandom);
            ex_uses_rt = 1'($urandom);
            idex_regwrite = 1'($urandom); idex_memread = 1'($urandom);
            exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            stall_clr = ($urandom_range(0, 19) == 0);
        end
        step(); idle_in();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
